// File: rtl/omsp_spm_cmd_arbiter.sv
// Arbitrates CPU and debug command requests towards the SPM control block.
// Define SPM_DBG_REQ_EN to enable the debug requester and round-robin arbitration.
module omsp_spm_cmd_arbiter #(
   parameter logic [9:0] TIMEOUT = 10'd1023
) (
   input  logic       mclk,
   input  logic       reset_n,

   input  logic       cpu_req,
   input  logic [1:0] cpu_cmd,
   output logic       cpu_ack,
   output logic       cpu_err,

   input  logic       dbg_req,
   input  logic [1:0] dbg_cmd,
   output logic       dbg_ack,
   output logic       dbg_err,

   output logic       update_spm,
   output logic       enable_spm,
   output logic       disable_spm,
   output logic       verify_spm,
   input  logic       violation,

   output logic       key_start,
   input  logic       key_done,

   output logic       busy,
   output logic       owner
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ISSUE  = 2'd1;
   localparam logic [1:0] KEYGEN = 2'd2;
   localparam logic [1:0] RESP   = 2'd3;

   localparam logic [1:0] CMD_PROTECT   = 2'b00;
   localparam logic [1:0] CMD_UNPROTECT = 2'b01;
   localparam logic [1:0] CMD_VERIFY    = 2'b10;
   localparam logic [1:0] CMD_RESERVED  = 2'b11;

   logic [1:0] state;
   logic [1:0] cmd_q;
   logic       owner_q;
   logic       last_owner_q;
   logic       err_q;
   logic [9:0] cnt_q;

   logic       dbg_req_eff;
   logic [1:0] dbg_cmd_eff;
   logic       req_any;
   logic       grant;
   logic [1:0] sel_cmd;

`ifdef SPM_DBG_REQ_EN
   assign dbg_req_eff = dbg_req;
   assign dbg_cmd_eff = dbg_cmd;
`else
   // Debug requester is invisible: owner can never latch 1, so it stays 0.
   logic unused_dbg;
   assign unused_dbg  = ^{dbg_req, dbg_cmd};
   assign dbg_req_eff = 1'b0;
   assign dbg_cmd_eff = 2'b00;
`endif

   // On a tie, the requester that was not served last wins.
   always_comb begin
      req_any = cpu_req | dbg_req_eff;
      if (cpu_req && dbg_req_eff) begin
         grant = ~last_owner_q;
      end else begin
         grant = dbg_req_eff;
      end
      sel_cmd = grant ? dbg_cmd_eff : cpu_cmd;
   end

   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         cmd_q        <= CMD_PROTECT;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         err_q        <= 1'b0;
         cnt_q        <= 10'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req_any) begin
                  owner_q <= grant;
                  cmd_q   <= sel_cmd;
                  cnt_q   <= 10'd0;
                  if (sel_cmd == CMD_RESERVED) begin
                     err_q <= 1'b1;
                     state <= RESP;
                  end else begin
                     err_q <= 1'b0;
                     state <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               err_q <= violation;
               cnt_q <= 10'd0;
               if (!violation && (cmd_q == CMD_PROTECT)) begin
                  state <= KEYGEN;
               end else begin
                  state <= RESP;
               end
            end
            // key_done takes priority over a timeout landing in the same cycle.
            KEYGEN: begin
               if (key_done) begin
                  err_q <= 1'b0;
                  state <= RESP;
               end else if (cnt_q == TIMEOUT) begin
                  err_q <= 1'b1;
                  state <= RESP;
               end else begin
                  cnt_q <= cnt_q + 10'd1;
               end
            end
            RESP: begin
               last_owner_q <= owner_q;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // All strobes are decoded from the registered state, so nothing glitches out of reset.
   always_comb begin
      update_spm  = (state == ISSUE) && ((cmd_q == CMD_PROTECT) || (cmd_q == CMD_UNPROTECT));
      enable_spm  = (state == ISSUE) && (cmd_q == CMD_PROTECT);
      disable_spm = (state == ISSUE) && (cmd_q == CMD_UNPROTECT);
      verify_spm  = (state == ISSUE) && (cmd_q == CMD_VERIFY);
      key_start   = (state == KEYGEN) && (cnt_q == 10'd0);
      cpu_ack     = (state == RESP) && !owner_q;
      cpu_err     = (state == RESP) && !owner_q && err_q;
      dbg_ack     = (state == RESP) && owner_q;
      dbg_err     = (state == RESP) && owner_q && err_q;
      busy        = (state != IDLE);
      owner       = owner_q;
   end

endmodule

// File: tb/tb_omsp_spm_cmd_arbiter.sv
// Scoreboard bench for omsp_spm_cmd_arbiter; expected output events are queued with their cycle.
module tb_omsp_spm_cmd_arbiter;

   logic       mclk = 1'b0;
   logic       reset_n;
   logic       cpu_req, dbg_req, violation, key_done;
   logic [1:0] cpu_cmd, dbg_cmd;
   logic       cpu_ack, cpu_err, dbg_ack, dbg_err;
   logic       update_spm, enable_spm, disable_spm, verify_spm;
   logic       key_start, busy, owner;

   localparam logic [8:0] E_UPD  = 9'b1_0000_0000;
   localparam logic [8:0] E_EN   = 9'b0_1000_0000;
   localparam logic [8:0] E_DIS  = 9'b0_0100_0000;
   localparam logic [8:0] E_VER  = 9'b0_0010_0000;
   localparam logic [8:0] E_KS   = 9'b0_0001_0000;
   localparam logic [8:0] E_CACK = 9'b0_0000_1000;
   localparam logic [8:0] E_CERR = 9'b0_0000_0100;
   localparam logic [8:0] E_DACK = 9'b0_0000_0010;
   localparam logic [8:0] E_DERR = 9'b0_0000_0001;

   typedef struct {
      int         cyc;
      logic [8:0] ev;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_bad = 0;
   int   t;
   logic [8:0] obs;
   exp_t mon_e;

   omsp_spm_cmd_arbiter #(.TIMEOUT(10'd8)) dut (
      .mclk        (mclk),
      .reset_n     (reset_n),
      .cpu_req     (cpu_req),
      .cpu_cmd     (cpu_cmd),
      .cpu_ack     (cpu_ack),
      .cpu_err     (cpu_err),
      .dbg_req     (dbg_req),
      .dbg_cmd     (dbg_cmd),
      .dbg_ack     (dbg_ack),
      .dbg_err     (dbg_err),
      .update_spm  (update_spm),
      .enable_spm  (enable_spm),
      .disable_spm (disable_spm),
      .verify_spm  (verify_spm),
      .violation   (violation),
      .key_start   (key_start),
      .key_done    (key_done),
      .busy        (busy),
      .owner       (owner)
   );

   always #5 mclk = ~mclk;

   always @(posedge mclk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_bad++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic expectEvent(input int c, input logic [8:0] ev);
      exp_t e;
      e.cyc = c;
      e.ev  = ev;
      exp_q.push_back(e);
   endtask

   task automatic gotoCycle(input int c);
      while (cyc < c) begin
         @(posedge mclk);
         #1;
      end
   endtask

   task automatic applyStimulus(input int c, input logic creq, input logic [1:0] ccmd,
                                input logic dreq, input logic [1:0] dcmd,
                                input logic kdone, input logic viol);
      gotoCycle(c);
      cpu_req   = creq;
      cpu_cmd   = ccmd;
      dbg_req   = dreq;
      dbg_cmd   = dcmd;
      key_done  = kdone;
      violation = viol;
   endtask

   // Monitor: any nonzero output event is matched against the head of the queue,
   // and expected events whose cycle has passed unobserved are reported as missing.
   always @(negedge mclk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         mon_e = exp_q.pop_front();
         n_checks++;
         n_bad++;
         $display("[TB] FAIL missing_event cycle=%0d actual=none required=%b", mon_e.cyc, mon_e.ev);
      end
      obs = {update_spm, enable_spm, disable_spm, verify_spm, key_start,
             cpu_ack, cpu_err, dbg_ack, dbg_err};
      if (obs != 9'd0) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_bad++;
            $display("[TB] FAIL unexpected_event cycle=%0d actual=%b required=none", cyc, obs);
         end else begin
            mon_e = exp_q.pop_front();
            checkOutput("event_cycle_bits", {32'(cyc), 23'd0, obs}, {32'(mon_e.cyc), 23'd0, mon_e.ev});
         end
      end
   end

   initial begin
      reset_n   = 1'b0;
      cpu_req   = 1'b0;
      cpu_cmd   = 2'b00;
      dbg_req   = 1'b0;
      dbg_cmd   = 2'b00;
      key_done  = 1'b0;
      violation = 1'b0;
      repeat (3) begin
         @(posedge mclk);
         #1;
      end
      @(negedge mclk);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_owner", 64'(owner), 64'd0);
      checkOutput("reset_outputs", 64'({update_spm, enable_spm, disable_spm, verify_spm,
                  key_start, cpu_ack, cpu_err, dbg_ack, dbg_err}), 64'd0);
      @(posedge mclk);
      #1;
      reset_n = 1'b1;

      // Protect, key_done five cycles after key_start
      t = cyc + 2;
      applyStimulus(t, 1, 2'b00, 0, 2'b00, 0, 0);
      expectEvent(t + 1, E_UPD | E_EN);
      expectEvent(t + 2, E_KS);
      expectEvent(t + 8, E_CACK);
      applyStimulus(t + 4, 1, 2'b00, 0, 2'b00, 0, 0);
      @(negedge mclk);
      checkOutput("busy_keygen", 64'(busy), 64'd1);
      applyStimulus(t + 7, 1, 2'b00, 0, 2'b00, 1, 0);
      applyStimulus(t + 8, 1, 2'b00, 0, 2'b00, 0, 0);
      applyStimulus(t + 9, 0, 2'b00, 0, 2'b00, 0, 0);

      // Protect with violation during ISSUE
      t = cyc + 2;
      applyStimulus(t, 1, 2'b00, 0, 2'b00, 0, 0);
      expectEvent(t + 1, E_UPD | E_EN);
      expectEvent(t + 2, E_CACK | E_CERR);
      applyStimulus(t + 1, 1, 2'b00, 0, 2'b00, 0, 1);
      applyStimulus(t + 2, 1, 2'b00, 0, 2'b00, 0, 0);
      applyStimulus(t + 3, 0, 2'b00, 0, 2'b00, 0, 0);
      @(negedge mclk);
      checkOutput("busy_after_violation", 64'(busy), 64'd0);

      // Unprotect; cmd change after latch must be ignored
      t = cyc + 2;
      applyStimulus(t, 1, 2'b01, 0, 2'b00, 0, 0);
      expectEvent(t + 1, E_UPD | E_DIS);
      expectEvent(t + 2, E_CACK);
      applyStimulus(t + 1, 1, 2'b10, 0, 2'b00, 0, 0);
      applyStimulus(t + 3, 0, 2'b00, 0, 2'b00, 0, 0);

      // Verify with req dropped mid-operation
      t = cyc + 2;
      applyStimulus(t, 1, 2'b10, 0, 2'b00, 0, 0);
      expectEvent(t + 1, E_VER);
      expectEvent(t + 2, E_CACK);
      applyStimulus(t + 1, 0, 2'b00, 0, 2'b00, 0, 0);

      // Reserved command from CPU
      t = cyc + 3;
      applyStimulus(t, 1, 2'b11, 0, 2'b00, 0, 0);
      expectEvent(t + 1, E_CACK | E_CERR);
      applyStimulus(t + 2, 0, 2'b00, 0, 2'b00, 0, 0);

      // Key-generation timeout (TIMEOUT=8)
      t = cyc + 2;
      applyStimulus(t, 1, 2'b00, 0, 2'b00, 0, 0);
      expectEvent(t + 1, E_UPD | E_EN);
      expectEvent(t + 2, E_KS);
      expectEvent(t + 11, E_CACK | E_CERR);
      applyStimulus(t + 10, 1, 2'b00, 0, 2'b00, 0, 0);
      @(negedge mclk);
      checkOutput("busy_last_keygen", 64'(busy), 64'd1);
      applyStimulus(t + 12, 0, 2'b00, 0, 2'b00, 0, 0);

      // key_done coincides with count==TIMEOUT: success wins
      t = cyc + 2;
      applyStimulus(t, 1, 2'b00, 0, 2'b00, 0, 0);
      expectEvent(t + 1, E_UPD | E_EN);
      expectEvent(t + 2, E_KS);
      applyStimulus(t + 10, 1, 2'b00, 0, 2'b00, 1, 0);
      expectEvent(t + 11, E_CACK);
      applyStimulus(t + 11, 1, 2'b00, 0, 2'b00, 0, 0);
      applyStimulus(t + 12, 0, 2'b00, 0, 2'b00, 0, 0);

      // Reset pulse during KEYGEN aborts silently
      t = cyc + 2;
      applyStimulus(t, 1, 2'b00, 0, 2'b00, 0, 0);
      expectEvent(t + 1, E_UPD | E_EN);
      expectEvent(t + 2, E_KS);
      applyStimulus(t + 4, 0, 2'b00, 0, 2'b00, 0, 0);
      reset_n = 1'b0;
      @(negedge mclk);
      checkOutput("busy_in_reset", 64'(busy), 64'd0);
      gotoCycle(t + 6);
      reset_n = 1'b1;
      @(negedge mclk);
      checkOutput("busy_after_reset", 64'(busy), 64'd0);

      // Normal service after reset
      t = cyc + 2;
      applyStimulus(t, 1, 2'b10, 0, 2'b00, 0, 0);
      expectEvent(t + 1, E_VER);
      expectEvent(t + 2, E_CACK);
      applyStimulus(t + 3, 0, 2'b00, 0, 2'b00, 0, 0);

`ifdef SPM_DBG_REQ_EN
      gotoCycle(cyc + 1);
      reset_n = 1'b0;
      gotoCycle(cyc + 2);
      reset_n = 1'b1;

      // Tie after reset: CPU first, debug next IDLE cycle
      t = cyc + 2;
      applyStimulus(t, 1, 2'b01, 1, 2'b01, 0, 0);
      expectEvent(t + 1, E_UPD | E_DIS);
      expectEvent(t + 2, E_CACK);
      applyStimulus(t + 3, 0, 2'b00, 1, 2'b01, 0, 0);
      expectEvent(t + 4, E_UPD | E_DIS);
      expectEvent(t + 5, E_DACK);
      applyStimulus(t + 4, 0, 2'b00, 1, 2'b01, 0, 0);
      @(negedge mclk);
      checkOutput("owner_debug", 64'(owner), 64'd1);
      applyStimulus(t + 6, 0, 2'b00, 0, 2'b00, 0, 0);

      // CPU served alone, then a tie goes to debug
      t = cyc + 2;
      applyStimulus(t, 1, 2'b10, 0, 2'b00, 0, 0);
      expectEvent(t + 1, E_VER);
      expectEvent(t + 2, E_CACK);
      applyStimulus(t + 3, 0, 2'b00, 0, 2'b00, 0, 0);
      t = cyc + 2;
      applyStimulus(t, 1, 2'b01, 1, 2'b10, 0, 0);
      expectEvent(t + 1, E_VER);
      expectEvent(t + 2, E_DACK);
      applyStimulus(t + 3, 1, 2'b01, 0, 2'b00, 0, 0);
      expectEvent(t + 4, E_UPD | E_DIS);
      expectEvent(t + 5, E_CACK);
      applyStimulus(t + 6, 0, 2'b00, 0, 2'b00, 0, 0);

      // Debug reserved command
      t = cyc + 2;
      applyStimulus(t, 0, 2'b00, 1, 2'b11, 0, 0);
      expectEvent(t + 1, E_DACK | E_DERR);
      applyStimulus(t + 2, 0, 2'b00, 0, 2'b00, 0, 0);
`else
      // Debug requests must be ignored entirely
      t = cyc + 2;
      applyStimulus(t, 0, 2'b00, 1, 2'b11, 0, 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge mclk);
         checkOutput("dbg_ignored_busy", 64'(busy), 64'd0);
         @(posedge mclk);
         #1;
      end
      t = cyc + 2;
      applyStimulus(t, 1, 2'b01, 1, 2'b11, 0, 0);
      expectEvent(t + 1, E_UPD | E_DIS);
      expectEvent(t + 2, E_CACK);
      applyStimulus(t + 1, 1, 2'b01, 1, 2'b11, 0, 0);
      @(negedge mclk);
      checkOutput("owner_cpu_only", 64'(owner), 64'd0);
      applyStimulus(t + 3, 0, 2'b00, 1, 2'b11, 0, 0);
      gotoCycle(t + 5);
      @(negedge mclk);
      checkOutput("dbg_ignored_after", 64'(busy), 64'd0);
      applyStimulus(t + 6, 0, 2'b00, 0, 2'b00, 0, 0);
`endif

      gotoCycle(cyc + 3);
      @(negedge mclk);
      #1;
      checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule

// File: doc/omsp_spm_cmd_arbiter.md
OMSP_SPM_CMD_ARBITER -- requirements
Module: omsp_spm_cmd_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 10'd1023: max KEYGEN wait cycles before error.
REQ-002 SHALL have port mclk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports cpu_req input 1, cpu_cmd input 2 (00 protect, 01 unprotect, 10 verify, 11 reserved): CPU requester.
REQ-005 SHALL have ports cpu_ack output 1 (one-cycle completion pulse), cpu_err output 1 (valid only with cpu_ack).
REQ-006 SHALL have ports dbg_req input 1, dbg_cmd input 2, dbg_ack output 1, dbg_err output 1: debug requester, same encoding.
REQ-007 SHALL have outputs update_spm, enable_spm, disable_spm, verify_spm (1 each): command strobes to SPM control.
REQ-008 SHALL have input violation 1: combinational violation from SPM control.
REQ-009 SHALL have output key_start 1 (pulse) and input key_done 1: key-derivation handshake.
REQ-010 SHALL have outputs busy 1 (state != IDLE) and owner 1 (0 CPU, 1 debug; current grant).

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE, KEYGEN, RESP.
REQ-012 IDLE: on any req, latch cmd and owner; go to ISSUE; reserved cmd goes directly to RESP with err=1.
REQ-013 Both req in same IDLE cycle: grant requester not served last (round-robin via last_owner register).
REQ-014 ISSUE (exactly one cycle): protect -> update_spm=1, enable_spm=1; unprotect -> update_spm=1, disable_spm=1; verify -> verify_spm=1; all other strobes 0.
REQ-015 ISSUE: sample violation into err; violation=1 -> RESP; protect without violation -> KEYGEN; unprotect/verify without violation -> RESP.
REQ-016 KEYGEN: key_start=1 in first KEYGEN cycle only; 10-bit wait counter cleared on entry, +1 per cycle.
REQ-017 KEYGEN: key_done=1 -> RESP err=0; counter==TIMEOUT without key_done -> RESP err=1; both same cycle -> key_done wins.
REQ-018 RESP (one cycle): ack=1 to latched owner only, err driven, other requester's ack/err=0; update last_owner; go to IDLE.
REQ-019 Latency from req seen in IDLE (cycle T0): unprotect/verify/violation ack at T0+2; reserved ack at T0+1; protect ack one cycle after key_done.
REQ-020 Requester SHALL hold req and cmd stable until ack and deassert req the cycle after ack; cmd changes after latch are ignored.
REQ-021 req dropped mid-operation: operation still completes and ack still pulses.
REQ-022 Strobes, key_start, ack, err SHALL be 0 in every state/cycle not listed above.

Reset
REQ-023 reset_n low: state=IDLE, counter=0, err=0, owner=0, last_owner=1 (CPU wins first tie), all outputs 0.
REQ-024 Reset mid-operation SHALL abort without ack; no strobe is issued during or in the first cycle after reset.

Configuration
REQ-025 Macro SPM_DBG_REQ_EN defined: debug requester and round-robin arbitration as above.
REQ-026 SPM_DBG_REQ_EN undefined: dbg_req/dbg_cmd ignored, dbg_ack=dbg_err=0, owner=0 constant, CPU always granted; ports remain present.

Verification
REQ-027 cpu_req, cmd=00, violation=0, key_done 5 cycles after key_start -> update_spm+enable_spm one cycle, key_start one cycle, cpu_ack=1 cpu_err=0 one cycle after key_done.
REQ-028 cpu_req, cmd=00, violation=1 in ISSUE -> no key_start, cpu_ack=1 cpu_err=1 at T0+2.
REQ-029 cpu_req and dbg_req both cmd=01 at same cycle after reset -> CPU served first (ack T0+2), debug granted next IDLE cycle, each sees one disable_spm pulse.
REQ-030 cmd=00, key_done never asserted, TIMEOUT=8 -> cpu_ack with cpu_err=1 after 8 KEYGEN cycles; key_done at count 8 -> err=0.
REQ-031 dbg_req cmd=11 -> no strobes, dbg_ack=1 dbg_err=1 at T0+1; without SPM_DBG_REQ_EN -> no response, busy stays 0.
REQ-032 reset_n pulsed low during KEYGEN -> busy=0, no ack, no strobes; next cpu_req serviced normally.
